// File: rtl/regfile_wb_pkg.sv
// Shared constants and helpers for the write-back register file with its
// pending-write scoreboard.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    // Per-register scoreboard action for one clock edge.
    typedef enum logic [1:0] {
        SB_HOLD  = 2'b00,
        SB_CLEAR = 2'b01,
        SB_SET   = 2'b10,
        SB_BOTH  = 2'b11
    } sb_op_e;

    // Next pending bit; a same-edge issue beats the write-back because the
    // newer producer is still outstanding.
    function automatic logic sb_next(input logic cur, input logic set, input logic clr);
        sb_op_e op;
        logic   nxt;
        op = sb_op_e'({set, clr});
        case (op)
            SB_HOLD:  nxt = cur;
            SB_CLEAR: nxt = 1'b0;
            SB_SET:   nxt = 1'b1;
            SB_BOTH:  nxt = 1'b1;
            default:  nxt = 1'b0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_wb_dest_decoder.sv
// One-hot decode of a destination register address; register 0 never selected.
module dest_decoder
    import regfile_wb_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                   i_en,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [(2**ADDR_W)-1:0] o_onehot
);

    // Address-to-one-hot with enable, bit 0 forced low.
    always_comb begin
        o_onehot = {(2**ADDR_W){1'b0}};
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end else begin
            o_onehot = {(2**ADDR_W){1'b0}};
        end
        o_onehot[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_wb.sv
// Register file with two combinational read ports, write-back bypass and a
// one-bit-per-register pending scoreboard driving a pipeline stall.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_wb_en,
    input  logic [ADDR_W-1:0] in_wb_addr,
    input  logic [DATA_W-1:0] in_wb_data,
    input  logic              in_issue_en,
    input  logic [ADDR_W-1:0] in_issue_addr,
    input  logic [ADDR_W-1:0] in_ra_addr,
    input  logic [ADDR_W-1:0] in_rb_addr,
    output logic [DATA_W-1:0] out_ra_data,
    output logic [DATA_W-1:0] out_rb_data,
    output logic              out_ra_busy,
    output logic              out_rb_busy,
    output logic              out_stall
);

    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pend;
    logic [NREG-1:0]   w_wr_vec;
    logic [NREG-1:0]   w_issue_vec;

    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];
    logic              w_rd_hit  [2];

    dest_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
        .i_en     (in_wb_en),
        .i_addr   (in_wb_addr),
        .o_onehot (w_wr_vec)
    );

    dest_decoder #(.ADDR_W(ADDR_W)) u_issue_dec (
        .i_en     (in_issue_en),
        .i_addr   (in_issue_addr),
        .o_onehot (w_issue_vec)
    );

    // Register storage; decoder never selects entry 0, so it stays zero.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_vec[i]) begin
                    r_regs[i] <= in_wb_data;
                end else begin
                    r_regs[i] <= r_regs[i];
                end
            end
        end
    end

    // Pending scoreboard, cleared by the same vector that writes the data.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_pend <= {NREG{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_pend[i] <= sb_next(r_pend[i], w_issue_vec[i], w_wr_vec[i]);
            end
        end
    end

    assign w_rd_addr[0] = in_ra_addr;
    assign w_rd_addr[1] = in_rb_addr;

    // Read ports: zero register, same-cycle bypass, else stored value; all
    // gated off while reset is held so no write-back data leaks through.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd_hit[p]  = 1'b0;
            w_rd_data[p] = {DATA_W{1'b0}};
            w_rd_busy[p] = 1'b0;
            if (!in_rst_n) begin
                w_rd_hit[p] = 1'b0;
            end else if (w_rd_addr[p] == {ADDR_W{1'b0}}) begin
                w_rd_hit[p] = 1'b0;
            end else begin
                w_rd_hit[p] = in_wb_en && (in_wb_addr == w_rd_addr[p]);
                if (w_rd_hit[p]) begin
                    w_rd_data[p] = in_wb_data;
                    w_rd_busy[p] = 1'b0;
                end else begin
                    w_rd_data[p] = r_regs[w_rd_addr[p]];
                    w_rd_busy[p] = r_pend[w_rd_addr[p]];
                end
            end
        end
    end

    assign out_ra_data = w_rd_data[0];
    assign out_rb_data = w_rd_data[1];
    assign out_ra_busy = w_rd_busy[0];
    assign out_rb_busy = w_rd_busy[1];
    assign out_stall   = w_rd_busy[0] | w_rd_busy[1];

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus random traffic
// against a behavioural model, expectations flowing through a scoreboard queue.
module tb_regfile_wb;

    logic        in_clk;
    logic        in_rst_n;
    logic        in_wb_en;
    logic [4:0]  in_wb_addr;
    logic [31:0] in_wb_data;
    logic        in_issue_en;
    logic [4:0]  in_issue_addr;
    logic [4:0]  in_ra_addr;
    logic [4:0]  in_rb_addr;
    logic [31:0] out_ra_data;
    logic [31:0] out_rb_data;
    logic        out_ra_busy;
    logic        out_rb_busy;
    logic        out_stall;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_wb_en      (in_wb_en),
        .in_wb_addr    (in_wb_addr),
        .in_wb_data    (in_wb_data),
        .in_issue_en   (in_issue_en),
        .in_issue_addr (in_issue_addr),
        .in_ra_addr    (in_ra_addr),
        .in_rb_addr    (in_rb_addr),
        .out_ra_data   (out_ra_data),
        .out_rb_data   (out_rb_data),
        .out_ra_busy   (out_ra_busy),
        .out_rb_busy   (out_rb_busy),
        .out_stall     (out_stall)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = out_ra_data;
                1:       obs = out_rb_data;
                2:       obs = {31'd0, out_ra_busy};
                3:       obs = {31'd0, out_rb_busy};
                default: obs = {31'd0, out_stall};
            endcase
            check_val(e.tag, obs, e.exp);
        end
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (!in_rst_n || a == 5'd0) return 32'd0;
        if (in_wb_en && in_wb_addr == a) return in_wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        if (!in_rst_n || a == 5'd0) return 1'b0;
        if (in_wb_en && in_wb_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic push_model(input string tag);
        push({tag, "_rad"}, 0, m_data(in_ra_addr));
        push({tag, "_rbd"}, 1, m_data(in_rb_addr));
        push({tag, "_rab"}, 2, {31'd0, m_busy(in_ra_addr)});
        push({tag, "_rbb"}, 3, {31'd0, m_busy(in_rb_addr)});
        push({tag, "_stl"}, 4, {31'd0, m_busy(in_ra_addr) | m_busy(in_rb_addr)});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                         input logic is, input logic [4:0] ia,
                         input logic [4:0] ra, input logic [4:0] rb);
        in_wb_en      = wb;
        in_wb_addr    = wa;
        in_wb_data    = wd;
        in_issue_en   = is;
        in_issue_addr = ia;
        in_ra_addr    = ra;
        in_rb_addr    = rb;
        #1;
    endtask

    // Advance one clock edge and update the model with the inputs seen there.
    task automatic tick();
        @(posedge in_clk);
        if (in_rst_n) begin
            if (in_wb_en && in_wb_addr != 5'd0) begin
                m_regs[in_wb_addr] = in_wb_data;
                m_pend[in_wb_addr] = 1'b0;
            end
            if (in_issue_en && in_issue_addr != 5'd0) m_pend[in_issue_addr] = 1'b1;
        end
        @(negedge in_clk);
    endtask

    initial begin
        model_reset();
        in_rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 5'd5, 5'd5);
        push("rst_rad", 0, 32'd0);
        push("rst_rbd", 1, 32'd0);
        push("rst_rab", 2, 32'd0);
        push("rst_rbb", 3, 32'd0);
        push("rst_stl", 4, 32'd0);
        drain();
        tick();
        tick();
        in_rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
        push("rst_ign", 0, 32'd0);
        push("rst_ign_b", 2, 32'd0);
        drain();

        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        push("wr5", 0, 32'hDEAD_BEEF);
        push("wr5_busy", 2, 32'd0);
        drain();

        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        push("r0_same", 0, 32'd0);
        push("r0_same_busy", 2, 32'd0);
        drain();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        push("r0_next", 0, 32'd0);
        push("r0_next_busy", 2, 32'd0);
        drain();

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
        push("r7_pend", 3, 32'd1);
        push("r7_pend_stl", 4, 32'd1);
        drain();
        drive(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 5'd7);
        push("byp7", 1, 32'h1234_5678);
        push("byp7_busy", 3, 32'd0);
        push("byp7_stl", 4, 32'd0);
        drain();
        tick();

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        push("sb9_busy", 2, 32'd1);
        push("sb9_stl", 4, 32'd1);
        drain();
        tick();
        drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 5'd9, 5'd0);
        push("sb9_wb_busy", 2, 32'd0);
        push("sb9_wb_stl", 4, 32'd0);
        drain();
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        push("sb9_after", 2, 32'd0);
        push("sb9_data", 0, 32'h0000_0099);
        drain();

        drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        push("same3_busy", 2, 32'd1);
        push("same3_data", 0, 32'h0000_0033);
        drain();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
        tick();
        drive(1'b1, 5'd3, 32'h0000_0034, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
        push("reiss3_busy", 2, 32'd0);
        push("reiss3_data", 0, 32'h0000_0034);
        drain();

        drive(1'b1, 5'd6, 32'h0000_0066, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0);
        push("np6_data", 0, 32'h0000_0066);
        push("np6_busy", 2, 32'd0);
        drain();

        drive(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b1, 5'd4, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        push("r4_pre_data", 0, 32'hA5A5_A5A5);
        push("r4_pre_busy", 2, 32'd1);
        drain();
        #2;
        in_rst_n = 1'b0;
        model_reset();
        #1;
        push("r4_rst_data", 0, 32'd0);
        push("r4_rst_busy", 2, 32'd0);
        push("r4_rst_stl", 4, 32'd0);
        drain();
        drive(1'b1, 5'd4, 32'h5555_5555, 1'b1, 5'd4, 5'd4, 5'd4);
        push("r4_rstwb_data", 0, 32'd0);
        drain();
        tick();
        in_rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        push("r4_post_data", 0, 32'd0);
        push("r4_post_busy", 2, 32'd0);
        drain();

        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(1)), 5'($urandom_range(15)), $urandom,
                  1'($urandom_range(1)), 5'($urandom_range(15)),
                  5'($urandom_range(15)), 5'($urandom_range(15)));
            push_model("rnd");
            drain();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; the register count is 2**ADDR_W.
REQ-003 The block SHALL have port in_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port in_rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port in_wb_en, input, 1, write-back request.
REQ-006 The block SHALL have port in_wb_addr, input, ADDR_W, the selected destination register (rt/rd mux output).
REQ-007 The block SHALL have port in_wb_data, input, DATA_W, write-back data.
REQ-008 The block SHALL have port in_issue_en, input, 1, an instruction with a destination has issued.
REQ-009 The block SHALL have port in_issue_addr, input, ADDR_W, the destination of the issued instruction.
REQ-010 The block SHALL have ports in_ra_addr and in_rb_addr, input, ADDR_W, the two read-port addresses.
REQ-011 The block SHALL have ports out_ra_data and out_rb_data, output, DATA_W, the read data.
REQ-012 The block SHALL have ports out_ra_busy and out_rb_busy, output, 1, read register has a write pending.
REQ-013 The block SHALL have port out_stall, output, 1, OR of out_ra_busy and out_rb_busy.

Function
REQ-014 Write: when in_wb_en=1 and in_wb_addr!=0, the block SHALL write in_wb_data into register in_wb_addr at the rising edge, through a one-hot decode of the address.
REQ-015 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded; address 0 SHALL never be busy.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-017 Bypass: when in_wb_en=1 and in_wb_addr equals a nonzero read address in the same cycle, that port SHALL return in_wb_data.
REQ-018 Scoreboard: each nonzero register SHALL have one pending bit.
REQ-019 in_issue_en=1 SHALL set the pending bit of in_issue_addr at the edge.
REQ-020 in_wb_en=1 SHALL clear the pending bit of in_wb_addr at the edge.
REQ-021 If issue and write-back target the same address in the same cycle, set SHALL win and the bit SHALL stay 1, because the newer producer is outstanding.
REQ-022 out_rX_busy SHALL be 1 iff the port's register is pending and not bypassed this cycle by an in_wb_en write to the same address.
REQ-023 A write-back to a non-pending register SHALL still write data and leave the bit 0, with no error.
REQ-024 Re-issue to an already pending register SHALL leave the bit 1; the scoreboard SHALL be a single bit per register, not a counter.
REQ-025 Outputs SHALL be purely combinational from state and inputs and SHALL contain no X after reset.

Reset
REQ-026 When in_rst_n is asserted low, the block SHALL immediately and asynchronously clear all registers to 0 and clear all pending bits.
REQ-027 During reset, out_ra_data, out_rb_data, out_ra_busy, out_rb_busy and out_stall SHALL all read 0.
REQ-028 Writes and issues presented while in_rst_n=0 SHALL be ignored.
REQ-029 Reset asserted mid-operation SHALL discard all pending state; the first edge after release SHALL operate normally.

Structure
REQ-030 The shared package SHALL hold the constants REG_ADDR_W=5, REG_DATA_W=32 and REG_ZERO=0.
REQ-031 The write-address decode SHALL be a sub-module named dest_decoder, mapping ADDR_W plus enable to a one-hot 2**ADDR_W write vector, with bit 0 forced to 0.
REQ-032 The write-enable vector from dest_decoder SHALL drive both the data-write enables and the pending-clear enables.

Verification
REQ-033 Write/readback: wb_en=1, addr=5, data=0xDEADBEEF; next cycle ra_addr=5 -> ra_data=0xDEADBEEF, busy=0.
REQ-034 Zero register: wb addr=0, data=0xFFFFFFFF; ra_addr=0 -> ra_data=0 in the same and following cycles, busy=0.
REQ-035 Bypass: in the same cycle wb addr=7, data=0x12345678 and rb_addr=7 -> rb_data=0x12345678; a pending r7 shows rb_busy=0, stall=0.
REQ-036 Scoreboard: issue addr=9; next cycle ra_addr=9 -> ra_busy=1, stall=1; wb addr=9 one cycle later -> busy clears at that cycle; the following cycle shows busy=0.
REQ-037 Same-cycle issue and wb to addr=3 -> data written, and next cycle ra_addr=3 gives ra_busy=1.
REQ-038 Reset mid-operation: r4=0xA5A5A5A5, r4 pending, then in_rst_n low between edges -> immediately ra_data=0 and busy=0 for r4; after release, r4 reads 0 and is not busy.
